dest_hazard_ctrl: RTL and testbench

Destination-register tracker and RAW-hazard stall controller for the five-stage pipeline (no forwarding). It registers the RegDst select that drives the EX-stage rt/rd destination multiplexer, and records each in-flight destination through EX, MEM and WB. It compares ID-stage source registers against those entries and asserts stall/bubble until the producer reaches write-back. It sits between the ID decode logic and the ID/EX latch, beside the hazard path for PC and IF/ID enables.

---
 rtl/dest_hazard_ctrl_if.sv | 34 +++
 rtl/dest_hazard_ctrl.sv | 101 ++++++++++
 tb/tb_dest_hazard_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dest_hazard_ctrl_if.sv
// Bundles the ID-stage decode fields and the hazard/EX-destination results
// exchanged between ID decode and the destination hazard controller.
interface dest_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic [4:0]       id_instr_1511;
  logic             id_regdst;
  logic             id_regwrite;
  logic             flush;
  logic             stall;
  logic             bubble;
  logic             ex_regdst;
  logic [4:0]       ex_dest;
  logic [CNT_W-1:0] stall_count;

  // ID decode side: drives the instruction fields, observes stall/bubble
  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_instr_1511, id_regdst, id_regwrite, flush,
    input  stall, bubble, ex_regdst, ex_dest, stall_count
  );

  // Hazard controller side
  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_instr_1511, id_regdst, id_regwrite, flush,
    output stall, bubble, ex_regdst, ex_dest, stall_count
  );
endinterface

// File: rtl/dest_hazard_ctrl.sv
// Destination-register scoreboard (EX/MEM/WB) and RAW-hazard stall control
// for a five-stage pipeline without forwarding. Also registers the RegDst
// select feeding the EX-stage rt/rd destination mux.
module dest_hazard_ctrl #(
  parameter bit WB_BYPASS = 1'b1,
  parameter int CNT_W     = 16
) (
  input logic             clk,
  input logic             rst,
  dest_hazard_ctrl_if.slave bus
);

  logic       e_v, m_v, w_v;
  logic [4:0] e_dest, m_dest, w_dest;
  logic       ex_regdst_q;
  logic [4:0] ex_dest_q;
  logic [CNT_W-1:0] cnt_q;

  logic [4:0] id_dest;
  logic       ins;
  logic       match_rs, match_rt;
  logic       hz;

  // Destination selection mirrors the EX-stage mux: rd when RegDst, else rt
  always_comb begin
    id_dest = bus.id_regdst ? bus.id_instr_1511 : bus.id_rt;
  end

  // Source comparison against in-flight producers; $0 never matches.
  // The WB entry only counts when the register file cannot bypass it.
  always_comb begin
    match_rs = 1'b0;
    match_rt = 1'b0;
    if (bus.id_rs != 5'd0) begin
      match_rs = (e_v && (e_dest == bus.id_rs)) ||
                 (m_v && (m_dest == bus.id_rs)) ||
                 (!WB_BYPASS && w_v && (w_dest == bus.id_rs));
    end
    if (bus.id_rt != 5'd0) begin
      match_rt = (e_v && (e_dest == bus.id_rt)) ||
                 (m_v && (m_dest == bus.id_rt)) ||
                 (!WB_BYPASS && w_v && (w_dest == bus.id_rt));
    end
  end

  // Flush discards the ID instruction, so it can neither stall nor insert
  always_comb begin
    hz  = bus.id_valid && !bus.flush &&
          ((bus.id_uses_rs && match_rs) || (bus.id_uses_rt && match_rt));
    ins = bus.id_valid && !hz && !bus.flush;
  end

  // Scoreboard shift: a stalled or flushed cycle inserts a bubble into E
  always_ff @(posedge clk) begin
    if (rst) begin
      e_v    <= 1'b0;
      m_v    <= 1'b0;
      w_v    <= 1'b0;
      e_dest <= 5'd0;
      m_dest <= 5'd0;
      w_dest <= 5'd0;
    end else begin
      w_v    <= m_v;
      w_dest <= m_dest;
      m_v    <= e_v;
      m_dest <= e_dest;
      e_v    <= ins && bus.id_regwrite && (id_dest != 5'd0);
      e_dest <= id_dest;
    end
  end

  // EX destination mux select and debug copy of the EX destination
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_regdst_q <= 1'b0;
      ex_dest_q   <= 5'd0;
    end else begin
      ex_regdst_q <= ins ? bus.id_regdst : 1'b0;
      ex_dest_q   <= ins ? id_dest : 5'd0;
    end
  end

  // Saturating stall-cycle counter; holds at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (hz && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Output drive
  always_comb begin
    bus.stall       = hz;
    bus.bubble      = hz || bus.flush;
    bus.ex_regdst   = ex_regdst_q;
    bus.ex_dest     = ex_dest_q;
    bus.stall_count = cnt_q;
  end

endmodule

// File: tb/tb_dest_hazard_ctrl.sv
// Bench for dest_hazard_ctrl: two instances (WB bypass with 16-bit counter,
// no bypass with 4-bit counter) driven by identical ID stimulus and checked
// against a producer-age reference model.
module tb_dest_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dest_hazard_ctrl_if #(.CNT_W(16)) bus_a ();
  dest_hazard_ctrl_if #(.CNT_W(4))  bus_b ();

  dest_hazard_ctrl #(.WB_BYPASS(1'b1), .CNT_W(16)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  dest_hazard_ctrl #(.WB_BYPASS(1'b0), .CNT_W(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int n_vec = 0;
  int n_err = 0;

  // current stimulus copy used by the model
  logic       s_valid, s_urs, s_urt, s_regdst, s_regwrite, s_flush, s_rst;
  logic [4:0] s_rs, s_rt, s_1511;

  // reference model: index 0 = bypass instance, 1 = no-bypass instance
  int   cyc;
  int   last_wr [2][32];
  int   m_cnt   [2];
  logic m_exrd  [2];
  int   m_exd   [2];
  logic es      [2];
  logic obs_st  [2];

  localparam int WIN  [2] = '{2, 3};
  localparam int CMAX [2] = '{65535, 15};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // a producer written at cycle t is in E/M/W during cycles t+1/t+2/t+3
  function automatic logic busy(input int d, input logic [4:0] s);
    int age;
    if (s == 5'd0) return 1'b0;
    age = cyc - last_wr[d][s];
    return (age >= 1) && (age <= WIN[d]);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 32; r++) last_wr[d][r] = -1000;
      m_cnt[d]  = 0;
      m_exrd[d] = 1'b0;
      m_exd[d]  = 0;
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] i1511,
                       input logic rd, input logic rw, input logic fl, input logic r);
    s_valid = v; s_rs = rs; s_rt = rt; s_urs = urs; s_urt = urt;
    s_1511 = i1511; s_regdst = rd; s_regwrite = rw; s_flush = fl; s_rst = r;
    rst = r;
    bus_a.id_valid = v;   bus_b.id_valid = v;
    bus_a.id_rs = rs;     bus_b.id_rs = rs;
    bus_a.id_rt = rt;     bus_b.id_rt = rt;
    bus_a.id_uses_rs = urs; bus_b.id_uses_rs = urs;
    bus_a.id_uses_rt = urt; bus_b.id_uses_rt = urt;
    bus_a.id_instr_1511 = i1511; bus_b.id_instr_1511 = i1511;
    bus_a.id_regdst = rd;   bus_b.id_regdst = rd;
    bus_a.id_regwrite = rw; bus_b.id_regwrite = rw;
    bus_a.flush = fl;       bus_b.flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // one clock: combinational checks, edge, model update, registered checks
  task automatic step(input bit comb);
    logic [4:0] dest;
    logic       ins;
    #1;
    for (int d = 0; d < 2; d++)
      es[d] = s_valid && !s_flush && ((s_urs && busy(d, s_rs)) || (s_urt && busy(d, s_rt)));
    obs_st[0] = bus_a.stall;
    obs_st[1] = bus_b.stall;
    if (comb) begin
      chk("stall_a",  {31'd0, bus_a.stall},  {31'd0, es[0]});
      chk("bubble_a", {31'd0, bus_a.bubble}, {31'd0, es[0] | s_flush});
      chk("stall_b",  {31'd0, bus_b.stall},  {31'd0, es[1]});
      chk("bubble_b", {31'd0, bus_b.bubble}, {31'd0, es[1] | s_flush});
    end
    @(posedge clk);
    if (s_rst) begin
      model_reset();
    end else begin
      dest = s_regdst ? s_1511 : s_rt;
      for (int d = 0; d < 2; d++) begin
        ins = s_valid && !es[d] && !s_flush;
        if (ins && s_regwrite && dest != 5'd0) last_wr[d][dest] = cyc;
        m_exrd[d] = ins ? s_regdst : 1'b0;
        m_exd[d]  = ins ? int'(dest) : 0;
        if (es[d] && m_cnt[d] < CMAX[d]) m_cnt[d]++;
      end
    end
    cyc++;
    #1;
    chk("ex_regdst_a",   {31'd0, bus_a.ex_regdst}, {31'd0, m_exrd[0]});
    chk("ex_dest_a",     {27'd0, bus_a.ex_dest},   m_exd[0]);
    chk("stall_count_a", {16'd0, bus_a.stall_count}, m_cnt[0]);
    chk("ex_regdst_b",   {31'd0, bus_b.ex_regdst}, {31'd0, m_exrd[1]});
    chk("ex_dest_b",     {27'd0, bus_b.ex_dest},   m_exd[1]);
    chk("stall_count_b", {28'd0, bus_b.stall_count}, m_cnt[1]);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1);
    idle();
  endtask

  // hold a consumer in ID until neither instance stalls; return stall cycles seen
  task automatic hold_consumer(input logic [4:0] rs, input logic [4:0] rt,
                               input logic urs, input logic urt,
                               output int na, output int nb);
    int k;
    na = 0; nb = 0; k = 0;
    drive(1'b1, rs, rt, urs, urt, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    do begin
      step(1'b1);
      if (obs_st[0] === 1'b1) na++;
      if (obs_st[1] === 1'b1) nb++;
      k++;
    end while ((obs_st[0] === 1'b1 || obs_st[1] === 1'b1) && k < 10);
    chk("consumer_bound", k < 10, 1);
    idle();
  endtask

  initial begin
    int na, nb;
    cyc = 0;
    model_reset();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0);
    idle();
    step(1'b1);

    // dependent R-type: add $3 then sub reading $3
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1);
    chk("add_ex_regdst", {31'd0, bus_a.ex_regdst}, 1);
    chk("add_ex_dest",   {27'd0, bus_a.ex_dest}, 3);
    hold_consumer(5'd3, 5'd0, 1'b1, 1'b0, na, nb);
    chk("raw_stall_len_bp",   na, 2);
    chk("raw_stall_len_nobp", nb, 3);
    chk("raw_count_bp",   {16'd0, bus_a.stall_count}, 2);
    chk("raw_count_nobp", {28'd0, bus_b.stall_count}, 3);

    // I-type destination: lw rt=5, rd field 9
    do_reset();
    drive(1'b1, 5'd1, 5'd5, 1'b1, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1);
    hold_consumer(5'd9, 5'd0, 1'b1, 1'b0, na, nb);
    chk("itype_rd_nostall", na, 0);
    do_reset();
    drive(1'b1, 5'd1, 5'd5, 1'b1, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1);
    hold_consumer(5'd0, 5'd5, 1'b0, 1'b1, na, nb);
    chk("itype_rt_stall", na, 2);

    // $0 destination and non-writing store
    do_reset();
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1);
    hold_consumer(5'd0, 5'd0, 1'b1, 1'b1, na, nb);
    chk("reg0_nostall", na + nb, 0);
    drive(1'b1, 5'd1, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1);
    hold_consumer(5'd4, 5'd4, 1'b1, 1'b1, na, nb);
    chk("store_nostall", na + nb, 0);

    // flush priority while add $3 sits in E; flushed instr would write $7
    do_reset();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1);
    drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    chk("flush_stall",  {31'd0, bus_a.stall},  0);
    chk("flush_bubble", {31'd0, bus_a.bubble}, 1);
    step(1'b1);
    chk("flush_ex_regdst", {31'd0, bus_a.ex_regdst}, 0);
    hold_consumer(5'd7, 5'd0, 1'b1, 1'b0, na, nb);
    chk("flush_entry_invalid", na, 0);

    // reset on first stall cycle of the dependent case
    do_reset();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1);
    drive(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1);
    drive(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rst_mid_stall",  {31'd0, bus_a.stall}, 0);
    chk("rst_mid_count",  {16'd0, bus_a.stall_count}, 0);
    chk("rst_mid_exdest", {27'd0, bus_a.ex_dest}, 0);
    step(1'b1);
    idle();

    // random traffic without reset, then check 4-bit counter saturation
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(9) != 0, 5'($urandom_range(3)), 5'($urandom_range(3)),
            1'($urandom), 1'($urandom), 5'($urandom_range(3)), 1'($urandom),
            1'($urandom), $urandom_range(9) == 0, 1'b0);
      step(1'b1);
    end
    chk("count_saturated_b", {28'd0, bus_b.stall_count}, 15);

    // random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(9) != 0, 5'($urandom_range(3)), 5'($urandom_range(3)),
            1'($urandom), 1'($urandom), 5'($urandom_range(3)), 1'($urandom),
            1'($urandom), $urandom_range(9) == 0, $urandom_range(49) == 0);
      step(1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
